// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered pop data, full/empty flags, sticky
// errors, push+pop exchange and saturating SP load. Optional: STACK_WATERMARK_EN.
module param_stack #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int PTR_WIDTH  = 7
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iPush,
   input  logic                  iPop,
   input  logic [DATA_WIDTH-1:0] iData,
   input  logic                  iSetSP,
   input  logic [PTR_WIDTH-1:0]  iSPValue,
   input  logic                  iClearErr,
   output logic [DATA_WIDTH-1:0] oData,
   output logic                  oValid,
   output logic [PTR_WIDTH-1:0]  oSP,
   output logic                  oFull,
   output logic                  oEmpty,
   output logic                  oOverflow,
`ifdef STACK_WATERMARK_EN
   output logic [PTR_WIDTH-1:0]  oHighWater,
`endif
   output logic                  oUnderflow
);

   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0]  DEPTH_SP = PTR_WIDTH'(DEPTH);
   localparam logic [PTR_WIDTH-1:0]  ONE_SP   = PTR_WIDTH'(32'd1);
   localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(32'd1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_WIDTH-1:0]  sp_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic                  valid_r;
   logic                  ovf_r;
   logic                  unf_r;

   logic                  full_s;
   logic                  empty_s;
   logic [ADDR_WIDTH-1:0] sp_addr_s;
   logic [ADDR_WIDTH-1:0] top_addr_s;
   logic [PTR_WIDTH-1:0]  sp_nxt_s;
   logic [DATA_WIDTH-1:0] data_nxt_s;
   logic                  valid_nxt_s;
   logic                  ovf_set_s;
   logic                  unf_set_s;
   logic                  ovf_nxt_s;
   logic                  unf_nxt_s;
   logic                  we_s;
   logic [ADDR_WIDTH-1:0] waddr_s;

   assign full_s    = (sp_r == DEPTH_SP);
   assign empty_s   = (sp_r == {PTR_WIDTH{1'b0}});
   // When SP == DEPTH the low address bits wrap, so top-1 still lands on the last entry.
   assign sp_addr_s  = sp_r[ADDR_WIDTH-1:0];
   assign top_addr_s = sp_addr_s - ONE_ADDR;

   // Next-state decode for push / pop / exchange / SP load.
   always_comb begin
      sp_nxt_s    = sp_r;
      data_nxt_s  = data_r;
      valid_nxt_s = 1'b0;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      we_s        = 1'b0;
      waddr_s     = sp_addr_s;
      case ({iPush, iPop})
         2'b10: begin
            if (full_s) begin
               ovf_set_s = 1'b1;
            end else begin
               we_s     = 1'b1;
               sp_nxt_s = sp_r + ONE_SP;
            end
         end
         2'b01: begin
            if (empty_s) begin
               unf_set_s = 1'b1;
            end else begin
               data_nxt_s  = mem_r[top_addr_s];
               valid_nxt_s = 1'b1;
               sp_nxt_s    = sp_r - ONE_SP;
            end
         end
         2'b11: begin
            valid_nxt_s = 1'b1;
            if (empty_s) begin
               data_nxt_s = iData;
            end else begin
               data_nxt_s = mem_r[top_addr_s];
               we_s       = 1'b1;
               waddr_s    = top_addr_s;
            end
         end
         2'b00: begin
            if (iSetSP) begin
               sp_nxt_s = (iSPValue > DEPTH_SP) ? DEPTH_SP : iSPValue;
            end else begin
               sp_nxt_s = sp_r;
            end
         end
         default: begin
            sp_nxt_s = sp_r;
         end
      endcase
   end

   // Sticky errors: a new event outranks a simultaneous clear.
   always_comb begin
      if (ovf_set_s) begin
         ovf_nxt_s = 1'b1;
      end else if (iClearErr) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
      if (unf_set_s) begin
         unf_nxt_s = 1'b1;
      end else if (iClearErr) begin
         unf_nxt_s = 1'b0;
      end else begin
         unf_nxt_s = unf_r;
      end
   end

   // Control and output registers.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         sp_r    <= {PTR_WIDTH{1'b0}};
         data_r  <= {DATA_WIDTH{1'b0}};
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         sp_r    <= sp_nxt_s;
         data_r  <= data_nxt_s;
         valid_r <= valid_nxt_s;
         ovf_r   <= ovf_nxt_s;
         unf_r   <= unf_nxt_s;
      end
   end

   // Storage array; not cleared by reset.
   always_ff @(posedge Clock) begin
      if (Reset && we_s) begin
         mem_r[waddr_s] <= iData;
      end
   end

`ifdef STACK_WATERMARK_EN
   logic [PTR_WIDTH-1:0] hw_r;
   logic [PTR_WIDTH-1:0] hw_base_s;
   logic [PTR_WIDTH-1:0] hw_nxt_s;

   // A clear restarts tracking from the current SP before folding in the next SP.
   always_comb begin
      if (iClearErr) begin
         hw_base_s = sp_r;
      end else begin
         hw_base_s = hw_r;
      end
      if (sp_nxt_s > hw_base_s) begin
         hw_nxt_s = sp_nxt_s;
      end else begin
         hw_nxt_s = hw_base_s;
      end
   end

   // High-water register.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         hw_r <= {PTR_WIDTH{1'b0}};
      end else begin
         hw_r <= hw_nxt_s;
      end
   end

   assign oHighWater = hw_r;
`endif

   assign oData      = data_r;
   assign oValid     = valid_r;
   assign oSP        = sp_r;
   assign oFull      = full_s;
   assign oEmpty     = empty_s;
   assign oOverflow  = ovf_r;
   assign oUnderflow = unf_r;

endmodule
